// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the fetch PC, issues word reads, tracks
// in-flight reads, buffers returned instructions for decode, squashes on redirect.

`ifndef PHYS_ADDR_WIDTH
`define PHYS_ADDR_WIDTH 32
`endif

package stage;
  typedef struct packed {
    logic                          valid;
    logic [`PHYS_ADDR_WIDTH-1:2]   addr;
    logic [31:0]                   insn;
  } InsnBundle;
endpackage

// state | meaning
// IDLE  | no request on the bus; waits for run and credit
// REQ   | mem_req_valid high, mem_req_addr held until accepted
module fetch_seq #(
  parameter int                    ADDR_WIDTH = `PHYS_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:2] redirect_addr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:2] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_insn,
  output stage::InsnBundle      out_bundle,
  input  logic                  out_ready
);

  localparam int AW = ADDR_WIDTH - 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:2] pc;
  logic [CW-1:0]         inflight, kill, fifo_cnt;
  logic                  stale;
  logic [PW-1:0]         wr_ptr, rd_ptr, aq_wr, aq_rd;

  logic [ADDR_WIDTH-1:2] aq_mem    [DEPTH];
  logic [ADDR_WIDTH-1:2] fifo_addr [DEPTH];
  logic [31:0]           fifo_insn [DEPTH];

  logic                  acc, rsp_live, push, pop, ok, ok_nxt;
  logic [CW-1:0]         inflight_nxt, kill_nxt, fifo_cnt_nxt;
  logic [ADDR_WIDTH-1:2] pc_after;

  always_comb begin
    acc          = mem_req_valid && mem_req_ready;
    rsp_live     = mem_rsp_valid && (inflight != '0);
    push         = rsp_live && (kill == '0) && !redirect_valid;
    pop          = (fifo_cnt != '0) && out_ready;
    inflight_nxt = inflight + CW'(acc) - CW'(rsp_live);
    fifo_cnt_nxt = redirect_valid ? '0 : fifo_cnt + CW'(push) - CW'(pop);
    ok           = ({1'b0, inflight} + {1'b0, fifo_cnt}) < DEPTH_L;
    ok_nxt       = ({1'b0, inflight_nxt} + {1'b0, fifo_cnt_nxt}) < DEPTH_L;
    // A stale (pre-redirect) request does not advance the pc when it goes out.
    if (redirect_valid) pc_after = redirect_addr;
    else if (stale)     pc_after = pc;
    else                pc_after = pc + AW'(1);
  end

  always_comb begin
    kill_nxt = kill;
    if (redirect_valid) begin
      kill_nxt = inflight_nxt;
    end else begin
      if (rsp_live && (kill != '0)) kill_nxt = kill_nxt - CW'(1);
      if (acc && stale)             kill_nxt = kill_nxt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_ADDR[ADDR_WIDTH-1:2];
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      inflight      <= '0;
      kill          <= '0;
      stale         <= 1'b0;
      fifo_cnt      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      aq_wr         <= '0;
      aq_rd         <= '0;
    end else begin
      inflight <= inflight_nxt;
      kill     <= kill_nxt;
      fifo_cnt <= fifo_cnt_nxt;
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      if (acc)      aq_wr <= aq_wr + PW'(1);
      if (rsp_live) aq_rd <= aq_rd + PW'(1);

      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc <= redirect_addr;
          end else if (run && ok) begin
            state         <= REQ;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= pc;
          end
        end
        REQ: begin
          if (acc) begin
            pc           <= pc_after;
            mem_req_addr <= pc_after;
            stale        <= 1'b0;
            if (!(run && ok_nxt)) begin
              state         <= IDLE;
              mem_req_valid <= 1'b0;
            end
          end else if (redirect_valid) begin
            pc    <= redirect_addr;
            stale <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (acc)  aq_mem[aq_wr] <= mem_req_addr;
    if (push) begin
      fifo_addr[wr_ptr] <= aq_mem[aq_rd];
      fifo_insn[wr_ptr] <= mem_rsp_insn;
    end
  end

  always_comb begin
    out_bundle = '0;
    if (fifo_cnt != '0) begin
      out_bundle.valid = 1'b1;
      out_bundle.addr  = fifo_addr[rd_ptr];
      out_bundle.insn  = fifo_insn[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: streaming vector table plus hand-written
// backpressure, redirect, wrap and mid-stream reset sequences.
module tb_fetch_seq;

  logic             clk = 1'b0;
  logic             rst_n, run, redirect_valid, mem_req_ready, mem_rsp_valid, out_ready;
  logic [31:2]      redirect_addr, mem_req_addr;
  logic             mem_req_valid;
  logic [31:0]      mem_rsp_insn;
  stage::InsnBundle out_bundle;

  fetch_seq dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_insn(mem_rsp_insn), .out_bundle(out_bundle), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;

  logic [29:0] mq_addr[$];
  int          mq_due[$];
  logic [29:0] acc_log[$];
  logic [29:0] got_addr[$];
  logic [31:0] got_insn[$];

  typedef struct {
    logic run, rdy, ordy;
    logic e_rv; logic [29:0] e_ra;
    logic e_ov; logic [29:0] e_oa;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [31:0] f(input logic [29:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a};
  endfunction

  function automatic logic [63:0] acc_at(input int i);
    return (acc_log.size() > i) ? {34'd0, acc_log[i]} : '1;
  endfunction

  function automatic logic [63:0] got_at(input int i);
    return (got_addr.size() > i) ? {34'd0, got_addr[i]} : '1;
  endfunction

  function automatic logic [63:0] ins_at(input int i);
    return (got_insn.size() > i) ? {32'd0, got_insn[i]} : '1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: present any due memory response, log accepts and pops, advance.
  task automatic tick();
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_insn  = f(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_insn  = 32'hDEAD_BEEF;
    end
    if (rst_n && mem_req_valid && mem_req_ready) begin
      acc_log.push_back(mem_req_addr);
      mq_addr.push_back(mem_req_addr);
      mq_due.push_back(cyc + lat);
    end
    if (rst_n && out_bundle.valid && out_ready) begin
      got_addr.push_back(out_bundle.addr);
      got_insn.push_back(out_bundle.insn);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_insn = '0; out_ready = 1'b0;
    mq_addr.delete(); mq_due.delete(); acc_log.delete(); got_addr.delete(); got_insn.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    // run rdy ordy | req_valid req_addr | out_valid out_addr
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 30'd0, 1'b0, 30'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 30'd0, 1'b0, 30'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 30'd1, 1'b0, 30'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 30'd2, 1'b1, 30'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 30'd3, 1'b1, 30'd1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 30'd4, 1'b1, 30'd2};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 30'd5, 1'b1, 30'd3};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 30'd6, 1'b1, 30'd4};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 30'd7, 1'b1, 30'd5};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 30'd8, 1'b1, 30'd6};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 30'd9, 1'b1, 30'd7};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 30'd0, 1'b1, 30'd8};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 30'd0, 1'b1, 30'd9};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 30'd0, 1'b0, 30'd0};

    // Reset state
    do_reset();
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_out_bundle", out_bundle, 0);

    // Streaming with 1-cycle memory, then run dropped
    lat = 1;
    foreach (tbl[i]) begin
      run = tbl[i].run; mem_req_ready = tbl[i].rdy; out_ready = tbl[i].ordy;
      chk($sformatf("stream%0d_req_valid", i), mem_req_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("stream%0d_req_addr", i), mem_req_addr, tbl[i].e_ra);
      chk($sformatf("stream%0d_out_valid", i), out_bundle.valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        chk($sformatf("stream%0d_out_addr", i), out_bundle.addr, tbl[i].e_oa);
        chk($sformatf("stream%0d_out_insn", i), out_bundle.insn, f(tbl[i].e_oa));
      end
      tick();
    end

    // Decode stalled: credit caps issue at DEPTH
    do_reset();
    lat = 1; run = 1'b1; mem_req_ready = 1'b1; out_ready = 1'b0;
    ticks(12);
    chk("bp_accept_count", acc_log.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_acc%0d", i), acc_at(i), i);
    chk("bp_req_valid_stalled", mem_req_valid, 0);
    chk("bp_head_addr", out_bundle.addr, 0);
    out_ready = 1'b1;
    ticks(12);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_got%0d_addr", i), got_at(i), i);
      chk($sformatf("bp_got%0d_insn", i), ins_at(i), f(30'(i)));
    end
    chk("bp_resume_addr", acc_at(4), 4);

    // Redirect with reads in flight
    do_reset();
    lat = 3; run = 1'b1; mem_req_ready = 1'b1; out_ready = 1'b1;
    ticks(3);
    redirect_valid = 1'b1; redirect_addr = 30'h100;
    tick();
    redirect_valid = 1'b0;
    ticks(15);
    chk("rd_acc_after_redirect", acc_at(3), 30'h100);
    chk("rd_first_bundle", got_at(0), 30'h100);
    chk("rd_first_insn", ins_at(0), f(30'h100));
    bad = 0;
    foreach (got_addr[i]) if (got_addr[i] < 30'h100) bad++;
    chk("rd_no_stale_bundles", bad, 0);

    // Redirect while the request is not yet accepted
    do_reset();
    lat = 1; run = 1'b1; mem_req_ready = 1'b0; out_ready = 1'b1;
    ticks(2);
    chk("hold_req_valid", mem_req_valid, 1);
    redirect_valid = 1'b1; redirect_addr = 30'h40;
    tick();
    redirect_valid = 1'b0;
    chk("hold_addr_after_redirect", mem_req_addr, 0);
    tick();
    chk("hold_addr_still", mem_req_addr, 0);
    mem_req_ready = 1'b1;
    ticks(10);
    chk("hold_acc0_old", acc_at(0), 0);
    chk("hold_acc1_new", acc_at(1), 30'h40);
    chk("hold_acc2_next", acc_at(2), 30'h41);
    chk("hold_first_bundle", got_at(0), 30'h40);

    // PC wrap at the top of the address space
    do_reset();
    redirect_valid = 1'b1; redirect_addr = 30'h3FFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    lat = 1; run = 1'b1; mem_req_ready = 1'b1; out_ready = 1'b1;
    ticks(8);
    chk("wrap_acc0", acc_at(0), 30'h3FFF_FFFF);
    chk("wrap_acc1", acc_at(1), 0);
    chk("wrap_got0", got_at(0), 30'h3FFF_FFFF);
    chk("wrap_got1", got_at(1), 0);
    chk("wrap_got1_insn", ins_at(1), f(30'd0));

    // Reset with reads in flight; late responses must be ignored
    do_reset();
    lat = 6; run = 1'b1; mem_req_ready = 1'b1; out_ready = 1'b0;
    ticks(6);
    chk("mr_inflight_cap", mem_req_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req_valid_async", mem_req_valid, 0);
    chk("mr_req_addr_async", mem_req_addr, 0);
    chk("mr_out_async", out_bundle, 0);
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_bundle.valid || mem_req_valid) bad++;
      tick();
    end
    chk("mr_stale_ignored", bad, 0);
    acc_log.delete(); got_addr.delete(); got_insn.delete();
    lat = 1; run = 1'b1; out_ready = 1'b1;
    ticks(6);
    chk("mr_first_req", acc_at(0), 0);
    chk("mr_first_bundle", got_at(0), 0);
    chk("mr_first_insn", ins_at(0), f(30'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
